// File: rtl/auc_alu.sv
// Modular arithmetic unit for the curve25519 ladder: ADD/SUB/CSWAP/COPY in one
// cycle, MUL/SQR/MULC as an MSB-first bit-serial interleaved multiply mod p.
module auc_alu #(
  parameter int              WID    = 256,
  parameter int              CURWID = 255,
  parameter int              OPWID  = 4,
  parameter logic [WID-1:0]  PRIME  = (WID'(1) << (WID - 1)) - WID'(19),
  parameter int              A24    = 121665,
  parameter int              A24WID = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             au_en,
  input  logic [OPWID-1:0] au_opcode,
  input  logic             au_carry,
  input  logic             au_swapop,
  input  logic             au_swapvl,
  input  logic [WID-1:0]   au_opa,
  input  logic [WID-1:0]   au_opb,
  output logic             au_vld,
  output logic [WID-1:0]   au_dat,
  output logic [WID-1:0]   au_rswap,
  output logic             au_busy,
  output logic             au_err
);

  localparam int CNTW = $clog2(CURWID);

  localparam logic [OPWID-1:0] OP_NOP   = OPWID'(0);
  localparam logic [OPWID-1:0] OP_ADD   = OPWID'(1);
  localparam logic [OPWID-1:0] OP_SUB   = OPWID'(2);
  localparam logic [OPWID-1:0] OP_MUL   = OPWID'(3);
  localparam logic [OPWID-1:0] OP_SQR   = OPWID'(4);
  localparam logic [OPWID-1:0] OP_MULC  = OPWID'(5);
  localparam logic [OPWID-1:0] OP_CSWAP = OPWID'(6);
  localparam logic [OPWID-1:0] OP_COPY  = OPWID'(7);

  localparam logic [WID:0] P_EXT = {1'b0, PRIME};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHORT,
    S_MLOOP,
    S_DONE
  } state_t;

  state_t            state;
  logic [OPWID-1:0]  op_q;
  logic              carry_q;
  logic              swap_q;
  logic              swapvl_q;
  logic [WID-1:0]    a_q;
  logic [WID-1:0]    b_q;
  logic [CURWID-1:0] mreg;
  logic [WID-1:0]    acc;
  logic [CNTW-1:0]   cnt;

  logic start;
  logic start_mul;

  assign start     = au_en && (state == S_IDLE || state == S_DONE);
  assign start_mul = !au_swapop &&
                     (au_opcode == OP_MUL || au_opcode == OP_SQR || au_opcode == OP_MULC);

  // Single-cycle operations, evaluated from the latched operands.
  logic [WID:0]   add_sum;
  logic [WID:0]   sub_dif;
  logic [WID-1:0] add_res;
  logic [WID-1:0] sub_res;
  logic [WID-1:0] short_dat;
  logic [WID-1:0] short_rswap;
  logic           short_swap;
  logic           short_err;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    short_dat   = '0;
    short_rswap = '0;
    short_swap  = 1'b0;
    short_err   = 1'b0;

    add_sum = {1'b0, a_q} + {1'b0, b_q};
    add_res = (add_sum >= P_EXT) ? WID'(add_sum - P_EXT) : add_sum[WID-1:0];

    sub_dif = carry_q ? ({1'b0, b_q} - {1'b0, a_q}) : ({1'b0, a_q} - {1'b0, b_q});
    sub_res = sub_dif[WID] ? WID'(sub_dif + P_EXT) : sub_dif[WID-1:0];

    if (swap_q || op_q == OP_CSWAP) begin
      short_swap  = 1'b1;
      short_dat   = swapvl_q ? b_q : a_q;
      short_rswap = swapvl_q ? a_q : b_q;
    end else begin
      case (op_q)
        OP_NOP:                    short_dat = '0;
        OP_ADD:                    short_dat = add_res;
        OP_SUB:                    short_dat = sub_res;
        OP_COPY:                   short_dat = a_q;
        OP_MUL, OP_SQR, OP_MULC:   short_dat = '0;
        default:                   short_err = 1'b1;
      endcase
    end
  end

  // One interleaved step: acc' = 2*acc + bit*a, then at most two reductions.
  logic [WID:0]   mul_t0;
  logic [WID:0]   mul_t1;
  logic [WID-1:0] mul_next;

  always_comb begin
    mul_t0   = {acc, 1'b0} + (mreg[cnt] ? {1'b0, a_q} : '0);
    mul_t1   = (mul_t0 >= P_EXT) ? (mul_t0 - P_EXT) : mul_t0;
    mul_next = (mul_t1 >= P_EXT) ? WID'(mul_t1 - P_EXT) : mul_t1[WID-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      carry_q  <= 1'b0;
      swap_q   <= 1'b0;
      swapvl_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      au_vld   <= 1'b0;
      au_err   <= 1'b0;
      au_busy  <= 1'b0;
      au_dat   <= '0;
      au_rswap <= '0;
    end else begin
      au_vld <= 1'b0;
      au_err <= 1'b0;

      if (start) begin
        op_q     <= au_opcode;
        carry_q  <= au_carry;
        swap_q   <= au_swapop;
        swapvl_q <= au_swapvl;
        a_q      <= au_opa;
        b_q      <= au_opb;
        acc      <= '0;
        au_busy  <= 1'b1;
        if (start_mul) begin
          state <= S_MLOOP;
          cnt   <= (au_opcode == OP_MULC) ? CNTW'(A24WID - 1) : CNTW'(CURWID - 1);
          mreg  <= (au_opcode == OP_MULC) ? CURWID'(A24) :
                   (au_opcode == OP_SQR)  ? au_opa[CURWID-1:0] : au_opb[CURWID-1:0];
        end else begin
          state <= S_SHORT;
        end
      end else begin
        case (state)
          S_SHORT: begin
            au_dat  <= short_dat;
            au_err  <= short_err;
            au_vld  <= 1'b1;
            au_busy <= 1'b0;
            if (short_swap) au_rswap <= short_rswap;
            state   <= S_DONE;
          end
          S_MLOOP: begin
            acc <= mul_next;
            cnt <= cnt - CNTW'(1);
            if (cnt == '0) begin
              au_dat  <= mul_next;
              au_vld  <= 1'b1;
              au_busy <= 1'b0;
              state   <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
